// File: rtl/if_fetch.sv
// MIPS instruction-fetch stage: PC owner, single-outstanding imem requester, 1-entry skid and
// IF/ID register, with delay-slot-aware redirect from decode.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] pc_out,
  output logic [31:0] instructure_out,
  input  logic        branch_in,
  input  logic [31:0] branch_addr,
  input  logic        jump_in,
  input  logic [25:0] jump_addr,
  input  logic        jump_reg_in,
  input  logic [31:0] jump_reg_addr
);

  logic [31:0] r_fetch_pc;
  logic        r_outstanding;
  logic [31:0] r_out_pc;
  logic        r_out_kill;
  logic        r_sk_valid;
  logic [31:0] r_sk_pc;
  logic [31:0] r_sk_instr;
  logic        r_id_valid;
  logic [31:0] r_pc_out;
  logic [31:0] r_instr_out;
  logic        r_redir_pending;
  logic [31:0] r_redir_target;

  logic        w_resp;
  logic        w_resp_live;
  logic        w_load;
  logic        w_to_skid;
  logic        w_accept;
  logic        w_redir;
  logic        w_d_issued;
  logic [31:0] w_d;
  logic [31:0] w_target;

  // Responses with nothing outstanding (e.g. stale ones across a reset) are ignored.
  assign w_resp      = imem_rvalid && r_outstanding;
  assign w_resp_live = w_resp && !r_out_kill;
  assign w_load      = !stall || !r_id_valid;
  assign w_to_skid   = w_resp_live && !w_load;

  // Also hold off while the skid is filling, so a later response always has a slot.
  assign imem_req  = reset && (!r_outstanding || imem_rvalid) && !r_sk_valid && !w_to_skid;
  assign imem_addr = r_fetch_pc;
  assign w_accept  = imem_req && imem_ready;

  assign w_redir    = r_id_valid && !stall && (branch_in || jump_in || jump_reg_in);
  assign w_d        = r_pc_out + 32'd4;
  assign w_d_issued = r_sk_valid || r_outstanding;

  always_comb begin
    w_target = w_d + (branch_addr << 2);
    if (jump_reg_in) begin
      w_target = jump_reg_addr & 32'hFFFF_FFFC;
    end else if (jump_in) begin
      w_target = {w_d[31:28], jump_addr, 2'b00};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc      <= RESET_PC;
      r_outstanding   <= 1'b0;
      r_out_pc        <= 32'd0;
      r_out_kill      <= 1'b0;
      r_sk_valid      <= 1'b0;
      r_sk_pc         <= 32'd0;
      r_sk_instr      <= 32'd0;
      r_id_valid      <= 1'b0;
      r_pc_out        <= 32'd0;
      r_instr_out     <= 32'd0;
      r_redir_pending <= 1'b0;
      r_redir_target  <= 32'd0;
    end else begin
      // A request issued alongside a redirect is younger than the delay slot when the slot
      // is already in the skid or responding now.
      if (w_accept) begin
        r_outstanding <= 1'b1;
        r_out_pc      <= r_fetch_pc;
        r_out_kill    <= w_redir && w_d_issued;
      end else begin
        if (w_resp) r_outstanding <= 1'b0;
        if (w_redir && r_sk_valid) r_out_kill <= 1'b1;
      end

      if (w_redir && w_d_issued) begin
        r_fetch_pc <= w_target;
      end else if (w_accept) begin
        if (r_redir_pending) begin
          r_fetch_pc      <= r_redir_target;
          r_redir_pending <= 1'b0;
        end else if (w_redir) begin
          r_fetch_pc <= w_target;
        end else begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
      end else if (w_redir) begin
        r_redir_pending <= 1'b1;
        r_redir_target  <= w_target;
      end

      if (w_load) begin
        if (r_sk_valid) begin
          r_id_valid  <= 1'b1;
          r_pc_out    <= r_sk_pc;
          r_instr_out <= r_sk_instr;
          r_sk_valid  <= w_resp_live && !w_redir;
          r_sk_pc     <= r_out_pc;
          r_sk_instr  <= imem_rdata;
        end else if (w_resp_live) begin
          r_id_valid  <= 1'b1;
          r_pc_out    <= r_out_pc;
          r_instr_out <= imem_rdata;
        end else begin
          r_id_valid <= 1'b0;
        end
      end else if (w_to_skid) begin
        r_sk_valid <= 1'b1;
        r_sk_pc    <= r_out_pc;
        r_sk_instr <= imem_rdata;
      end
    end
  end

  assign id_valid        = r_id_valid;
  assign pc_out          = r_pc_out;
  assign instructure_out = r_instr_out;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: imem model, decode model, and two scoreboards (IF/ID and request order).
module tb_if_fetch;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] pc_out;
  logic [31:0] instructure_out;
  logic        branch_in;
  logic [31:0] branch_addr;
  logic        jump_in;
  logic [25:0] jump_addr;
  logic        jump_reg_in;
  logic [31:0] jump_reg_addr;

  if_fetch #(.RESET_PC(32'h0000_3000)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .pc_out         (pc_out),
    .instructure_out(instructure_out),
    .branch_in      (branch_in),
    .branch_addr    (branch_addr),
    .jump_in        (jump_in),
    .jump_addr      (jump_addr),
    .jump_reg_in    (jump_reg_in),
    .jump_reg_addr  (jump_reg_addr)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_pc[$];
  logic [31:0] exp_ins[$];
  logic [31:0] exp_req[$];

  // imem model and decode model controls
  int          lat = 1;
  logic        force_stall = 1'b1;
  logic [31:0] st_pc = 32'd0;
  int          st_left = 0;
  logic        br_armed = 1'b0;
  int          br_kind = 0;
  logic [31:0] br_pc = 32'd0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, want finished", $time);
    $fatal(1, "global timeout");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic push_id(input logic [31:0] pc);
    exp_pc.push_back(pc);
    exp_ins.push_back(pc ^ KEY);
  endtask

  // imem: accepts sampled mid-cycle, response after lat cycles; survives DUT reset on purpose.
  initial begin
    logic        acc;
    logic [31:0] acc_addr;
    logic        pend;
    logic [31:0] paddr;
    int          cnt;
    pend = 1'b0;
    paddr = 32'd0;
    cnt = 0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      acc = imem_req && imem_ready;
      acc_addr = imem_addr;
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (acc) begin
        pend = 1'b1;
        cnt = lat;
        paddr = acc_addr;
      end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata = paddr ^ KEY;
          pend = 1'b0;
        end
      end
    end
  end

  // Decode model: holds a redirect on the armed PC until it is taken without stall.
  initial begin
    logic br_fired;
    logic stall_now;
    br_fired = 1'b0;
    stall = 1'b1;
    branch_in = 1'b0;
    jump_in = 1'b0;
    jump_reg_in = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (br_fired) br_armed = 1'b0;
      br_fired = 1'b0;
      stall_now = force_stall;
      if (reset && id_valid && pc_out == st_pc && st_left > 0) begin
        stall_now = 1'b1;
        st_left--;
      end
      stall = stall_now;
      branch_in = 1'b0;
      jump_in = 1'b0;
      jump_reg_in = 1'b0;
      if (reset && br_armed && id_valid && pc_out == br_pc) begin
        case (br_kind)
          1: branch_in = 1'b1;
          2: jump_in = 1'b1;
          default: jump_reg_in = 1'b1;
        endcase
        if (!stall_now) br_fired = 1'b1;
      end
    end
  end

  // IF/ID monitor: an instruction is consumed when it leaves IF/ID.
  always @(negedge clk) begin
    if (reset && id_valid && !stall && exp_pc.size() > 0) begin
      logic [31:0] wpc;
      logic [31:0] wins;
      wpc = exp_pc.pop_front();
      wins = exp_ins.pop_front();
      chk("ifid_pc", pc_out, wpc);
      chk("ifid_instr", instructure_out, wins);
    end
  end

  // Request monitor: order of accepted imem addresses.
  always @(negedge clk) begin
    if (imem_req && imem_ready && exp_req.size() > 0) begin
      logic [31:0] wa;
      wa = exp_req.pop_front();
      chk("req_addr", imem_addr, wa);
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    force_stall = 1'b1;
    st_left = 0;
    br_armed = 1'b0;
    imem_ready = 1'b0;
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic release_reset(input logic hold_stall);
    force_stall = hold_stall;
    imem_ready = 1'b1;
    @(posedge clk);
    #3;
    reset = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_pc.size() != 0 || exp_req.size() != 0) && n < 300) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_pc.size() != 0 || exp_req.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d IF/ID and %0d requests still expected, want 0", name,
               exp_pc.size(), exp_req.size());
      exp_pc.delete();
      exp_ins.delete();
      exp_req.delete();
    end
  endtask

  initial begin
    reset = 1'b0;
    imem_ready = 1'b0;
    branch_addr = 32'd0;
    jump_addr = 26'd0;
    jump_reg_addr = 32'd0;

    // Reset state and straight-line streaming at latency 1
    lat = 1;
    do_reset();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h3000);
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    chk("rst_instr", instructure_out, 32'd0);
    for (int i = 0; i < 6; i++) begin
      push_id(32'h3000 + 32'(4 * i));
      exp_req.push_back(32'h3000 + 32'(4 * i));
    end
    release_reset(1'b0);
    #1;
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h3000);
    @(posedge clk);
    #1;
    chk("id_valid_c1", {31'd0, id_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("id_valid_c2", {31'd0, id_valid}, 32'd1);
    chk("pc_c2", pc_out, 32'h3000);
    @(posedge clk);
    #1;
    chk("pc_c3", pc_out, 32'h3004);
    @(posedge clk);
    #1;
    chk("pc_c4", pc_out, 32'h3008);
    wait_done("stream");

    // Taken branch at 0x3010, offset -4 words
    do_reset();
    br_armed = 1'b1;
    br_kind = 1;
    br_pc = 32'h3010;
    branch_addr = 32'hFFFF_FFFC;
    for (int i = 0; i < 6; i++) push_id(32'h3000 + 32'(4 * i));
    push_id(32'h3004);
    push_id(32'h3008);
    push_id(32'h300C);
    for (int i = 0; i < 7; i++) exp_req.push_back(32'h3000 + 32'(4 * i));
    exp_req.push_back(32'h3004);
    exp_req.push_back(32'h3008);
    release_reset(1'b0);
    wait_done("branch");

    // jr at 0x3000 to 0x4003, latency 3
    lat = 3;
    do_reset();
    br_armed = 1'b1;
    br_kind = 3;
    br_pc = 32'h3000;
    jump_reg_addr = 32'h0000_4003;
    push_id(32'h3000);
    push_id(32'h3004);
    push_id(32'h4000);
    push_id(32'h4004);
    exp_req.push_back(32'h3000);
    exp_req.push_back(32'h3004);
    exp_req.push_back(32'h4000);
    exp_req.push_back(32'h4004);
    release_reset(1'b0);
    wait_done("jr");

    // j at 0x3000 while decode stalls 3 cycles
    lat = 1;
    do_reset();
    br_armed = 1'b1;
    br_kind = 2;
    br_pc = 32'h3000;
    jump_addr = 26'h0000C40;
    st_pc = 32'h3000;
    st_left = 3;
    push_id(32'h3000);
    push_id(32'h3004);
    push_id(32'h3100);
    push_id(32'h3104);
    exp_req.push_back(32'h3000);
    exp_req.push_back(32'h3004);
    exp_req.push_back(32'h3100);
    exp_req.push_back(32'h3104);
    release_reset(1'b0);
    wait_done("j_stall");

    // imem_ready low for 4 cycles while 0x3008 is pending
    do_reset();
    for (int i = 0; i < 6; i++) begin
      push_id(32'h3000 + 32'(4 * i));
      exp_req.push_back(32'h3000 + 32'(4 * i));
    end
    release_reset(1'b0);
    repeat (2) @(posedge clk);
    #1;
    imem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #2;
      chk("nrdy_req", {31'd0, imem_req}, 32'd1);
      chk("nrdy_addr", imem_addr, 32'h3008);
      @(posedge clk);
      #1;
    end
    imem_ready = 1'b1;
    wait_done("not_ready");

    // Partial-cycle reset pulse with a late response, latency 4
    lat = 4;
    do_reset();
    exp_req.push_back(32'h3000);
    exp_req.push_back(32'h3004);
    exp_req.push_back(32'h3000);
    exp_req.push_back(32'h3004);
    release_reset(1'b1);
    repeat (6) @(posedge clk);
    #1;
    chk("pre_pulse_valid", {31'd0, id_valid}, 32'd1);
    chk("pre_pulse_pc", pc_out, 32'h3000);
    imem_ready = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    chk("pulse_id_valid", {31'd0, id_valid}, 32'd0);
    chk("pulse_pc_out", pc_out, 32'd0);
    chk("pulse_instr", instructure_out, 32'd0);
    chk("pulse_req", {31'd0, imem_req}, 32'd0);
    #1;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("late_drop_valid", {31'd0, id_valid}, 32'd0);
    chk("restart_req", {31'd0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr, 32'h3000);
    push_id(32'h3000);
    push_id(32'h3004);
    imem_ready = 1'b1;
    force_stall = 1'b0;
    wait_done("reset_pulse");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
